keypad_entry_ctrl: RTL
======================

# keypad_entry_ctrl

Sequencing controller that sits behind the 4x4 keypad row/column scanner on the 1 kHz clock domain. Groups the scanner's per-row key samples into 4-cycle scan frames, debounces the frame result, and turns each debounced key press into one event. Events drive a numeric-entry state machine that assembles up to four BCD digits and commits the value on an Enter key, for the seven-segment display and downstream logic.

## Interface
- DEBOUNCE_FRAMES, 5, consecutive identical frame results needed to accept a key state change; legal range 2..15 (5 frames = 20 ms)
- clk_1khz  input  1  system clock, shared with the scanner
- rst  input  1  synchronous reset, active-high
- key_code  input  4  scanner key code, 0..15
- key_valid  input  1  scanner strobe; key_code is meaningful when high
- disp_bcd  output  16  entry buffer, digit 0 in [3:0]; reset 0
- digit_cnt  output  3  digits held, 0..4; reset 0
- value  output  16  last committed BCD value; reset 0
- value_valid  output  1  one-cycle commit pulse; reset 0
- key_evt  output  1  one-cycle debounced press pulse; reset 0
- key_evt_code  output  4  code of the last press event; reset 0
- err  output  1  one-cycle rejected-key pulse; reset 0

## Operation
- Frame counter fc (2 bits) free-runs 0..3 and wraps. It is not aligned to the scanner, because any 4 consecutive cycles cover all rows.
- Within a frame, each cycle with key_valid=1 sets hit and captures key_code. If several keys appear in one frame, the last captured code wins.
- At fc==3, the frame result is {hit, code}, where code is forced to 0 when hit=0. hit and code then clear for the next frame.
- Debounce uses the registers cand, cnt, and stable:
  - If result==cand, cnt saturates upward at DEBOUNCE_FRAMES.
  - Otherwise, cand takes the result and cnt becomes 1.
  - When cnt reaches DEBOUNCE_FRAMES and cand!=stable, stable takes cand.
- A press event fires when stable becomes a hit. This covers none->key and also keyA->keyB, which counts as a new press of B. Release (key->none) produces no event.
- Entry FSM states: EMPTY (digit_cnt=0), ENTRY (1..3), FULL (4), COMMIT (one cycle).
  - Key 0..9 in EMPTY or ENTRY: disp_bcd shifts left 4 bits, the key enters [3:0], and digit_cnt increments. The FSM moves to ENTRY, or to FULL at the 4th digit.
  - Key 0..9 in FULL: buffer unchanged, err pulses.
  - Key 10 (backspace): disp_bcd shifts right 4 bits and digit_cnt decrements. In EMPTY it causes an err pulse and no change.
  - Key 11 (clear): buffer and digit_cnt go to 0 and the FSM moves to EMPTY. Clear in EMPTY is silent.
  - Key 15 (enter) in ENTRY or FULL: value takes disp_bcd (right-aligned, leading digits 0) and the FSM moves to COMMIT. In EMPTY, enter causes an err pulse.
  - Keys 12..14: ignored, no err.
  - COMMIT: value_valid=1, buffer and digit_cnt cleared, the FSM moves to EMPTY next cycle. No key event can arrive in COMMIT, since events are at least 4 cycles apart.
- Reset at any point clears fc, the frame registers, cand, cnt, stable (no key), the FSM (EMPTY), and all outputs. A key held across reset is accepted as a new press after DEBOUNCE_FRAMES full frames.

## Timing
- Frame result is evaluated on the fc==3 edge. key_evt and key_evt_code are registered and high in the cycle after the frame-end edge that updates stable.
- The FSM acts on key_evt in the same cycle. disp_bcd, digit_cnt, and err update on the following edge, so they are visible 1 cycle after key_evt.
- Enter: value updates and the FSM enters COMMIT one cycle after key_evt. value_valid is high that cycle. disp_bcd and digit_cnt read 0 one cycle later.
- Minimum press-to-key_evt latency: DEBOUNCE_FRAMES frames = 4*DEBOUNCE_FRAMES cycles (+1 register) after the first fully covered frame.
- A held key produces exactly one key_evt regardless of duration.
- A glitch or bounce lasting fewer than DEBOUNCE_FRAMES consecutive frames produces no event and no stable change.

## Test plan
- Reset: hold rst for 3 cycles with key_valid toggling. All outputs must read 0, digit_cnt=0, and no key_evt may appear for the next 4*DEBOUNCE_FRAMES cycles.
- Entry and commit: press and release 1, 2, 3, then 15, each held 30 frames. Expect 4 key_evt pulses, disp_bcd 0x0001 -> 0x0012 -> 0x0123, value=0x0123, and value_valid high exactly 1 cycle. disp_bcd and digit_cnt must then read 0.
- Bounce rejection: a key-5 hit alternating every 2 frames for 40 frames, then steady for 4 frames (DEBOUNCE_FRAMES=5). Expect no key_evt. Extending the steady period to 5 frames must give exactly one key_evt with code 5.
- Overflow and backspace: digits 9, 8, 7, 6, 5. The fifth must give err=1 with disp_bcd staying 0x9876. Then key 10 gives 0x0987 and digit_cnt=3.
- Empty errors and slide: enter on empty and backspace on empty must each give one err pulse. Holding 4 and then sliding directly to 7 must give key_evt codes 4 then 7, and disp_bcd=0x0047.
- Reset mid-entry: after digits 3 and 1, assert rst while key 2 is held. disp_bcd must read 0, and the held key 2 must produce key_evt only after 5 post-reset frames.

Source files
------------

// File: rtl/keypad_entry_ctrl_if.sv
// Keypad entry bus: scanner samples in, entry buffer / commit / event outputs back.
interface keypad_entry_ctrl_if;
  logic [3:0]  key_code;
  logic        key_valid;
  logic [15:0] disp_bcd;
  logic [2:0]  digit_cnt;
  logic [15:0] value;
  logic        value_valid;
  logic        key_evt;
  logic [3:0]  key_evt_code;
  logic        err;

  // Master drives scanner samples and observes the controller.
  modport master (
    output key_code, key_valid,
    input  disp_bcd, digit_cnt, value, value_valid, key_evt, key_evt_code, err
  );

  // Slave is the controller itself.
  modport slave (
    input  key_code, key_valid,
    output disp_bcd, digit_cnt, value, value_valid, key_evt, key_evt_code, err
  );
endinterface

// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller: frames scanner samples, debounces frame results,
// emits one event per press and assembles up to four BCD digits for commit.
module keypad_entry_ctrl #(
  parameter int unsigned DEBOUNCE_FRAMES = 5
) (
  input logic                clk_1khz,
  input logic                rst,
  keypad_entry_ctrl_if.slave bus
);

  localparam logic [3:0] DbMax = 4'(DEBOUNCE_FRAMES);

  typedef enum logic [1:0] {StEmpty, StEntry, StFull, StCommit} state_e;

  logic [1:0]  fc_q;
  logic        hit_q;
  logic [3:0]  code_q;
  logic [4:0]  result;
  logic [4:0]  cand_q, cand_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [4:0]  stable_q, stable_d;
  logic        evt_d;
  logic        key_evt_q;
  logic [3:0]  key_evt_code_q;

  state_e      state_q, state_d;
  logic [15:0] entry_q, entry_d;
  logic [2:0]  dcnt_q, dcnt_d;
  logic [15:0] value_q, value_d;
  logic        err_q, err_d;

  // Frame result includes the sample taken in the frame's last cycle.
  always_comb begin
    result = {hit_q | bus.key_valid, bus.key_valid ? bus.key_code : code_q};
  end

  // Debounce: count identical frame results, promote candidate once stable long enough.
  always_comb begin
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    evt_d    = 1'b0;
    if (fc_q == 2'd3) begin
      if (result == cand_q) begin
        if (cnt_q < DbMax) cnt_d = cnt_q + 4'd1;
      end else begin
        cand_d = result;
        cnt_d  = 4'd1;
      end
      if (cnt_d == DbMax && cand_d != stable_q) begin
        stable_d = cand_d;
        evt_d    = cand_d[4];  // releases update stable silently
      end
    end
  end

  // Frame accumulation, debounce state and registered press event.
  always_ff @(posedge clk_1khz) begin
    if (rst) begin
      fc_q           <= 2'd0;
      hit_q          <= 1'b0;
      code_q         <= 4'd0;
      cand_q         <= 5'd0;
      cnt_q          <= 4'd0;
      stable_q       <= 5'd0;
      key_evt_q      <= 1'b0;
      key_evt_code_q <= 4'd0;
    end else begin
      fc_q <= fc_q + 2'd1;
      if (fc_q == 2'd3) begin
        hit_q  <= 1'b0;
        code_q <= 4'd0;
      end else if (bus.key_valid) begin
        hit_q  <= 1'b1;
        code_q <= bus.key_code;
      end
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      stable_q  <= stable_d;
      key_evt_q <= evt_d;
      if (evt_d) key_evt_code_q <= cand_d[3:0];
    end
  end

  // Entry FSM: reacts to the press event in the cycle it is high.
  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    dcnt_d  = dcnt_q;
    value_d = value_q;
    err_d   = 1'b0;
    if (state_q == StCommit) begin
      entry_d = 16'd0;
      dcnt_d  = 3'd0;
      state_d = StEmpty;
    end else if (key_evt_q) begin
      if (key_evt_code_q <= 4'd9) begin
        if (state_q == StFull) begin
          err_d = 1'b1;
        end else begin
          entry_d = {entry_q[11:0], key_evt_code_q};
          dcnt_d  = dcnt_q + 3'd1;
          state_d = (dcnt_q == 3'd3) ? StFull : StEntry;
        end
      end else if (key_evt_code_q == 4'd10) begin
        if (state_q == StEmpty) begin
          err_d = 1'b1;
        end else begin
          entry_d = {4'd0, entry_q[15:4]};
          dcnt_d  = dcnt_q - 3'd1;
          state_d = (dcnt_q == 3'd1) ? StEmpty : StEntry;
        end
      end else if (key_evt_code_q == 4'd11) begin
        entry_d = 16'd0;
        dcnt_d  = 3'd0;
        state_d = StEmpty;
      end else if (key_evt_code_q == 4'd15) begin
        if (state_q == StEmpty) begin
          err_d = 1'b1;
        end else begin
          value_d = entry_q;
          state_d = StCommit;
        end
      end
    end
  end

  // Entry FSM state and output registers.
  always_ff @(posedge clk_1khz) begin
    if (rst) begin
      state_q <= StEmpty;
      entry_q <= 16'd0;
      dcnt_q  <= 3'd0;
      value_q <= 16'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      dcnt_q  <= dcnt_d;
      value_q <= value_d;
      err_q   <= err_d;
    end
  end

  // Output mapping onto the bus.
  always_comb begin
    bus.disp_bcd     = entry_q;
    bus.digit_cnt    = dcnt_q;
    bus.value        = value_q;
    bus.value_valid  = (state_q == StCommit);
    bus.key_evt      = key_evt_q;
    bus.key_evt_code = key_evt_code_q;
    bus.err          = err_q;
  end

endmodule
